// File: rtl/axis_decimator_pkg.sv
// Shared types and elaboration helpers for the multi-channel AXI-stream decimator.
package axis_decimator_pkg;

  typedef enum logic {
    DECIM_DROP    = 1'b0,
    DECIM_AVERAGE = 1'b1
  } decim_mode_t;

  // Ratio arrays are handed to package helpers flattened into 32-bit slots.
  localparam int MAX_CHANNELS = 32;
  typedef logic [MAX_CHANNELS*32-1:0] ratio_vec_t;

  function automatic int max_ratio(input ratio_vec_t r, input int n);
    int m;
    m = 0;
    for (int i = 0; i < n; i++) begin
      if (int'(r[i*32 +: 32]) > m) m = int'(r[i*32 +: 32]);
    end
    return m;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/axi_stream.sv
// Minimal AXI-stream bundle: data, destination and valid/ready handshake.
interface axi_stream #(
  parameter int DATA_WIDTH = 32,
  parameter int DEST_WIDTH = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [DEST_WIDTH-1:0] tdest;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tdest, output tvalid, input tready);
  modport slave  (input tdata, input tdest, input tvalid, output tready);
endinterface

// File: rtl/decimator_channel.sv
// One decimation channel: window counter plus accumulator; emit/result are
// combinational from the incoming sample so the top can register them once.
module decimator_channel
  import axis_decimator_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          CNT_WIDTH  = 3,
  parameter int          ACC_WIDTH  = 35,
  parameter int          RATIO      = 1,
  parameter decim_mode_t MODE       = DECIM_DROP
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  hit_i,
  input  logic [DATA_WIDTH-1:0] sample_i,
  output logic                  emit_o,
  output logic [DATA_WIDTH-1:0] result_o
);

  localparam int                   SHIFT = $clog2(RATIO);
  localparam logic [CNT_WIDTH-1:0] LAST  = CNT_WIDTH'(RATIO - 1);

  logic [CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0]       avg;
  logic                        last;

  assign last = (cnt_q == LAST);
  assign sum  = acc_q + {{(ACC_WIDTH-DATA_WIDTH){sample_i[DATA_WIDTH-1]}}, sample_i};
  // Power-of-two ratio makes the mean an arithmetic shift (floor rounding).
  assign avg  = DATA_WIDTH'(sum >>> SHIFT);

  assign emit_o   = hit_i && last;
  assign result_o = (MODE == DECIM_AVERAGE) ? avg : sample_i;

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    if (clear_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (hit_i) begin
      if (last) begin
        cnt_d = '0;
        acc_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_WIDTH'(1);
        acc_d = (MODE == DECIM_AVERAGE) ? sum : '0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/axis_channel_decimator.sv
// Multi-channel AXI-stream decimator: tdest decode, per-channel windows and a
// single registered output slot with pass-through backpressure.
module axis_channel_decimator
  import axis_decimator_pkg::*;
#(
  parameter int          DATA_WIDTH = 32,
  parameter int          N_CHANNELS = 4,
  parameter int          DECIMATION_RATIOS [N_CHANNELS-1:0] = '{8, 4, 2, 1},
  parameter decim_mode_t MODE = DECIM_DROP
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      clear,
  axi_stream.slave  data_in,
  axi_stream.master data_out,
  output logic      invalid_dest
);

  function automatic ratio_vec_t pack_ratios();
    ratio_vec_t v;
    v = '0;
    for (int i = 0; i < N_CHANNELS; i++) v[i*32 +: 32] = DECIMATION_RATIOS[i];
    return v;
  endfunction

  localparam int DEST_WIDTH = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
  localparam int MAX_RATIO  = max_ratio(pack_ratios(), N_CHANNELS);
  localparam int CNT_WIDTH  = (MAX_RATIO > 1) ? $clog2(MAX_RATIO) : 1;
  localparam int ACC_WIDTH  = DATA_WIDTH + CNT_WIDTH;

  if (N_CHANNELS > MAX_CHANNELS) begin : g_err_nch
    $error("axis_channel_decimator: N_CHANNELS exceeds MAX_CHANNELS");
  end

  logic                                 accept, dest_ok;
  logic [N_CHANNELS-1:0]                hit, emit;
  logic [N_CHANNELS-1:0][DATA_WIDTH-1:0] result;
  logic                                 any_emit;
  logic [DATA_WIDTH-1:0]                emit_data;
  logic [DEST_WIDTH-1:0]                emit_dest;

  logic                  vld_q, vld_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DEST_WIDTH-1:0] dest_q, dest_d;
  logic                  inv_q, inv_d;

  assign data_in.tready = reset && !clear && (!vld_q || data_out.tready);
  assign accept         = data_in.tvalid && data_in.tready;
  // tdest is compared at its full incoming width so out-of-range codes are seen.
  assign dest_ok        = int'(data_in.tdest) < N_CHANNELS;

  for (genvar c = 0; c < N_CHANNELS; c++) begin : g_ch
    if (DECIMATION_RATIOS[c] < 1) begin : g_err_lo
      $error("axis_channel_decimator: ratio below 1 on channel %0d", c);
    end
    if (DECIMATION_RATIOS[c] > 2**CNT_WIDTH) begin : g_err_hi
      $error("axis_channel_decimator: ratio exceeds counter range on channel %0d", c);
    end
    if (MODE == DECIM_AVERAGE && !is_pow2(DECIMATION_RATIOS[c])) begin : g_err_p2
      $error("axis_channel_decimator: AVERAGE ratio not a power of two on channel %0d", c);
    end

    assign hit[c] = accept && (int'(data_in.tdest) == c);

    decimator_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .CNT_WIDTH  (CNT_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .RATIO      (DECIMATION_RATIOS[c]),
      .MODE       (MODE)
    ) u_ch (
      .clk_i    (clock),
      .rst_ni   (reset),
      .clear_i  (clear),
      .hit_i    (hit[c]),
      .sample_i (data_in.tdata),
      .emit_o   (emit[c]),
      .result_o (result[c])
    );
  end

  // At most one channel is hit per cycle, so a priority-free select suffices.
  always_comb begin
    any_emit  = |emit;
    emit_data = '0;
    emit_dest = '0;
    for (int c = 0; c < N_CHANNELS; c++) begin
      if (emit[c]) begin
        emit_data = result[c];
        emit_dest = DEST_WIDTH'(c);
      end
    end
  end

  always_comb begin
    vld_d  = vld_q;
    data_d = data_q;
    dest_d = dest_q;
    inv_d  = accept && !dest_ok;
    if (any_emit) begin
      vld_d  = 1'b1;
      data_d = emit_data;
      dest_d = emit_dest;
    end else if (data_out.tready) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      dest_q <= '0;
      inv_q  <= 1'b0;
    end else begin
      vld_q  <= vld_d;
      data_q <= data_d;
      dest_q <= dest_d;
      inv_q  <= inv_d;
    end
  end

  assign data_out.tvalid = vld_q;
  assign data_out.tdata  = data_q;
  assign data_out.tdest  = dest_q;
  assign invalid_dest    = inv_q;

endmodule

// File: tb/tb_axis_channel_decimator.sv
// Scoreboard bench: DROP and AVERAGE instances share stimulus; a window model
// predicts each channel's output and a negedge monitor compares.
module tb_axis_channel_decimator;
  import axis_decimator_pkg::*;

  localparam int NCH = 4;
  localparam int RATIO [NCH] = '{1, 2, 4, 8};

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [2:0]  in_dest = '0;
  logic        out_ready = 1'b0;
  logic        inv_a, inv_b;
  bit          force_stall = 1'b0;
  int          ready_pct = 100;

  always #5 clock = ~clock;

  axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(3)) in_a ();
  axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(3)) in_b ();
  axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(2)) out_a ();
  axi_stream #(.DATA_WIDTH(32), .DEST_WIDTH(2)) out_b ();

  assign in_a.tvalid = in_valid;
  assign in_a.tdata  = in_data;
  assign in_a.tdest  = in_dest;
  assign in_b.tvalid = in_valid;
  assign in_b.tdata  = in_data;
  assign in_b.tdest  = in_dest;
  assign out_a.tready = out_ready;
  assign out_b.tready = out_ready;

  axis_channel_decimator #(
    .DATA_WIDTH(32), .N_CHANNELS(4), .DECIMATION_RATIOS('{8, 4, 2, 1}), .MODE(DECIM_DROP)
  ) u_drop (
    .clock(clock), .reset(reset), .clear(clear),
    .data_in(in_a), .data_out(out_a), .invalid_dest(inv_a)
  );

  axis_channel_decimator #(
    .DATA_WIDTH(32), .N_CHANNELS(4), .DECIMATION_RATIOS('{8, 4, 2, 1}), .MODE(DECIM_AVERAGE)
  ) u_avg (
    .clock(clock), .reset(reset), .clear(clear),
    .data_in(in_b), .data_out(out_b), .invalid_dest(inv_b)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  dest;
  } beat_t;

  beat_t exp_a[$];
  beat_t exp_b[$];
  int    win[NCH][$];
  bit    exp_inv = 1'b0;
  int    n_checks = 0;
  int    n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] avg_floor(input longint s, input int r);
    longint q;
    q = s / r;
    if ((s % r) != 0 && s < 0) q = q - 1;
    return q[31:0];
  endfunction

  // Window model: collect samples per channel; a full window yields the last
  // sample (DROP) and the floored mean (AVERAGE).
  task automatic model_beat(input int d, input logic [31:0] v);
    longint s;
    beat_t  ba, bb;
    if (d >= NCH) return;
    win[d].push_back(int'(v));
    if (win[d].size() == RATIO[d]) begin
      s = 0;
      foreach (win[d][i]) s += longint'(win[d][i]);
      ba.data = v;                    ba.dest = 2'(d);
      bb.data = avg_floor(s, RATIO[d]); bb.dest = 2'(d);
      exp_a.push_back(ba);
      exp_b.push_back(bb);
      win[d].delete();
    end
  endtask

  always @(negedge clock) begin
    beat_t ea, eb;
    logic  rdy_a, rdy_b;
    rdy_a = reset && !clear && (exp_a.size() == 0 || out_ready);
    rdy_b = reset && !clear && (exp_b.size() == 0 || out_ready);
    check("in_tready_drop", in_a.tready, rdy_a);
    check("in_tready_avg", in_b.tready, rdy_b);
    check("out_tvalid_drop", out_a.tvalid, exp_a.size() != 0);
    check("out_tvalid_avg", out_b.tvalid, exp_b.size() != 0);
    check("invalid_dest_drop", inv_a, exp_inv);
    check("invalid_dest_avg", inv_b, exp_inv);
    if (!reset) begin
      exp_a.delete();
      exp_b.delete();
      for (int i = 0; i < NCH; i++) win[i].delete();
      exp_inv = 1'b0;
    end else begin
      if (out_a.tvalid && out_ready && exp_a.size() > 0) begin
        ea = exp_a.pop_front();
        check("out_data_drop", out_a.tdata, ea.data);
        check("out_dest_drop", out_a.tdest, ea.dest);
      end
      if (out_b.tvalid && out_ready && exp_b.size() > 0) begin
        eb = exp_b.pop_front();
        check("out_data_avg", out_b.tdata, eb.data);
        check("out_dest_avg", out_b.tdest, eb.dest);
      end
      exp_inv = in_valid && in_a.tready && (in_dest >= NCH);
      if (clear) begin
        for (int i = 0; i < NCH; i++) win[i].delete();
      end else if (in_valid && in_a.tready) begin
        model_beat(int'(in_dest), in_data);
      end
    end
  end

  // Downstream sink: random or forced-low ready, changed just after each edge.
  initial forever begin
    @(posedge clock);
    #1;
    out_ready = force_stall ? 1'b0 : ($urandom_range(0, 99) < ready_pct);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int d, input logic [31:0] v);
    int t;
    in_dest  = 3'(d);
    in_data  = v;
    in_valid = 1'b1;
    t = 0;
    do begin
      @(negedge clock);
      t++;
    end while (!in_a.tready && t < 100);
    if (!in_a.tready) check("send_timeout", in_a.tready, 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clock);
    check({tag, "_tdata_drop"}, out_a.tdata, 0);
    check({tag, "_tdest_drop"}, out_a.tdest, 0);
    check({tag, "_tdata_avg"}, out_b.tdata, 0);
    check({tag, "_tdest_avg"}, out_b.tdest, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    reset = 1'b0;
    repeat (2) tick();
    check_idle_outputs("reset_state");
    tick();
    reset = 1'b1;
    tick();

    // DROP/AVERAGE on ch1 (R=2), data 1..8
    for (int i = 1; i <= 8; i++) send(1, 32'(i));

    // ch3 (R=8): seven -3 then -2, mean floors to -3
    for (int i = 0; i < 7; i++) send(3, -32'sd3);
    send(3, -32'sd2);

    // Interleaved ch0/ch2 with a 5+ cycle downstream stall
    force_stall = 1'b1;
    tick(); tick();
    fork
      begin repeat (6) tick(); force_stall = 1'b0; end
      begin
        for (int i = 0; i < 4; i++) begin
          send(0, $urandom);
          send(2, $urandom);
        end
      end
    join

    // Out-of-range destinations, then confirm ch1 window alignment is intact
    send(5, 32'h1234);
    tick();
    send(7, 32'h5678);
    send(1, 32'd40);
    send(1, 32'd41);

    // Partial ch2 window flushed by clear, then a full window of 10
    for (int i = 0; i < 3; i++) send(2, 32'd1000 + 32'(i));
    do_clear();
    for (int i = 0; i < 4; i++) send(2, 32'd10);

    // Reset with a pending output and ch3 mid-window
    force_stall = 1'b1;
    tick(); tick();
    send(3, 32'd1); send(3, 32'd2); send(3, 32'd3);
    send(0, 32'd55);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_idle_outputs("after_reset");
    check("after_reset_inv", inv_a, 0);
    force_stall = 1'b0;
    for (int i = 0; i < 8; i++) send(3, 32'(i * 3 - 7));

    // Randomized traffic with random backpressure, clears and bad tdest
    ready_pct = 70;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) do_clear();
      else if (r < 7) send($urandom_range(4, 7), $urandom);
      else if (r < 10) tick();
      else if (r < 55) send($urandom_range(0, 3), $urandom);
      else send($urandom_range(0, 3), 32'($urandom_range(0, 40)) - 32'd20);
    end

    ready_pct = 100;
    repeat (10) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_channel_decimator.md
# axis_channel_decimator

Parametrised multi-channel AXI-stream decimator for the acquisition path. It sits between ADC/processing stages and the scope or DMA. Interleaved samples tagged by `tdest` are reduced per channel by an elaboration-time ratio array. In DROP mode a channel forwards every Nth sample; in AVERAGE mode it forwards the mean of each N-sample window. Ratios, accumulator widths and channel-index widths are all derived from parameter expressions.

## Interface
- `DATA_WIDTH`, 32: `tdata` width; samples are signed two's complement.
- `N_CHANNELS`, 4: number of channels.
- `DECIMATION_RATIOS [N_CHANNELS-1:0]`, `'{8, 4, 2, 1}`: per-channel ratio; element i applies to `tdest == i`.
- `MODE`, `DECIM_DROP`: `DECIM_DROP` or `DECIM_AVERAGE` (package enum).
- `DEST_WIDTH` (localparam): `$clog2(N_CHANNELS)`, minimum 1.
- `MAX_RATIO` (localparam): maximum of `DECIMATION_RATIOS`.
- `CNT_WIDTH` (localparam): `$clog2(MAX_RATIO)`, minimum 1.
- `ACC_WIDTH` (localparam): `DATA_WIDTH + CNT_WIDTH`.
- `clock`, in, 1: single clock domain.
- `reset`, in, 1: synchronous, active-low.
- `clear`, in, 1: synchronous flush of all channel windows.
- `data_in`, `axi_stream.slave`, `DATA_WIDTH`/`DEST_WIDTH`: sample stream with `tdata`, `tdest`, `tvalid` and `tready`.
- `data_out`, `axi_stream.master`, same widths: decimated stream; `tdest` carries the channel.
- `invalid_dest`, out, 1: one-cycle pulse when an accepted beat has `tdest >= N_CHANNELS`.

## Operation
- Each channel has a window counter `cnt` (`CNT_WIDTH`) and an accumulator `acc` (`ACC_WIDTH`).
- A beat is accepted when `data_in.tvalid && data_in.tready`.
- On an accepted beat for channel c with ratio R:
  - If `cnt == R-1`: emit and set `cnt` to 0.
  - Otherwise: increment `cnt`.
- DROP mode emits the sample at window index R-1, i.e. the last sample of the window.
- AVERAGE mode:
  - Sign-extend each sample into `acc`.
  - On emit, output `(acc + sample) >>> $clog2(R)`, using an arithmetic shift (floor rounding), and truncate to `DATA_WIDTH`.
  - Set `acc` to 0.
- R = 1 is pass-through in both modes.
- Channels are independent; interleaving order is arbitrary.
- A beat with `tdest >= N_CHANNELS` is accepted and discarded. It pulses `invalid_dest` and changes no channel state.
- `clear` high:
  - Zeroes every `cnt` and `acc`.
  - Drives `data_in.tready` low, so no beat is accepted in that cycle.
  - Leaves a pending output beat untouched.
- Elaboration checks, each raising `$error`:
  - Any ratio < 1.
  - Any ratio > `2**CNT_WIDTH`.
  - AVERAGE mode with a ratio that is not a power of two.

## Timing
- Output is a single registered slot, with no combinational path from input to output.
- Latency: a beat that triggers an emit at edge k drives `data_out.tvalid` high from edge k onward.
- `data_in.tready = reset && !clear && (!data_out.tvalid || data_out.tready)`. This applies to all beats, including non-emitting ones.
- Output slot handshake:
  - The slot holds `tdata`/`tdest` stable while `tvalid && !tready`.
  - Simultaneous drain and refill in one cycle is allowed; the slot goes back to back with no bubble.
- Reset low at an edge clears everything in that cycle, including mid-window and with a pending output:
  - Output slot: `tvalid`=0, `tdata`=0, `tdest`=0.
  - `invalid_dest`=0.
  - All `cnt` and `acc` = 0.
- Reset overrides `clear`.
- Throughput: one beat per cycle while `data_out` is not stalled.

## Structure
- `axis_decimator_pkg`:
  - `decim_mode_t` enum (`DECIM_DROP`, `DECIM_AVERAGE`).
  - `max_ratio()` function over the ratio array.
  - `is_pow2()` function.
- Sub-module `decimator_channel`, generated `N_CHANNELS` times:
  - Holds `cnt`/`acc` for its ratio R.
  - Produces `emit` and `result` combinationally from the incoming sample.
- Top level contains:
  - `tdest` decode.
  - Output slot register.
  - `tready` logic.
  - `invalid_dest` register.

## Test plan
- DROP, ratios `'{8,4,2,1}`, 8 beats on ch1 with data 1..8 → outputs 2, 4, 6, 8, each with `tdest`=1.
- AVERAGE, ch3 (R=8), data -3,-3,-3,-3,-3,-3,-3,-2 → single output -3 (floor of -23/8), `tdest`=3.
- Interleaved ch0/ch2, `data_out.tready` held low for 5 cycles during an emit → `data_in.tready` low and output stable; release yields the correct ordered outputs with no loss.
- Beat with `tdest`=5 when `N_CHANNELS`=4 → `invalid_dest` high for exactly 1 cycle, no output, ch0–ch3 window counts unchanged.
- AVERAGE ch2 (R=4) with 3 beats, then `clear` for 1 cycle, then 4 beats of 10 → single output 10; `tready`=0 during `clear`.
- Reset low with `data_out.tvalid`=1 and ch3 mid-window → next cycle all outputs 0; the following 8 ch3 beats produce exactly one output.
